y_tap_line_buffer: RTL and testbench
====================================

Name: y_tap_line_buffer

Overview:
- Vertical tap window generator directly upstream of the y-direction weight-table stage.
- Consumes the raster stream of horizontally interpolated samples (15-bit, 8 integer + 7 fraction) from the x stage.
- Stores the three previous lines and presents four vertically aligned samples (rows n-3..n, same column) each cycle, feeding the weight stage's in_0..in_3.

Parameters:
- LINE_WIDTH, 64, samples per line (≥2).
- ADDR_W, 6, column counter width; 2^ADDR_W ≥ LINE_WIDTH.
- DATA_W, 15, sample width (8 integer + 7 fraction).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on posedge clk.
- in_valid  input  1  in_data/in_sof valid this cycle.
- in_sof  input  1  first sample of a frame; qualified by in_valid.
- in_data  input  DATA_W  horizontally interpolated sample, raster order.
- out_valid  output  1  taps valid.
- tap_0  output  DATA_W  sample at row n-3 (oldest); drives weight stage in_0.
- tap_1  output  DATA_W  row n-2; drives in_1.
- tap_2  output  DATA_W  row n-1; drives in_2.
- tap_3  output  DATA_W  row n (current input); drives in_3.
- out_col  output  ADDR_W  column index of the taps.
- out_eol  output  1  taps belong to the last column (LINE_WIDTH-1).

Behaviour:
- Reset (rst=0 at posedge):
  - out_valid=0, out_eol=0; tap_0..tap_3=0; out_col=0.
  - col_cnt=0, wr_sel=0, state=IDLE.
  - Line RAM contents are not cleared.
- Storage: three line memories L0..L2, LINE_WIDTH×DATA_W each. wr_sel (0..2) selects the line being overwritten.
- Per accepted sample (in_valid=1 in FILL/STREAM, or the sof sample):
  - L[wr_sel][col] is read before it is written in the same cycle.
  - tap_0 ← L[wr_sel][col]; tap_1 ← L[(wr_sel+1)%3][col]; tap_2 ← L[(wr_sel+2)%3][col]; tap_3 ← in_data.
  - L[wr_sel][col] ← in_data.
  - out_col ← col; out_eol ← (col==LINE_WIDTH-1).
  - Column wrap: col_cnt → 0 and wr_sel → (wr_sel+1)%3 when col==LINE_WIDTH-1; otherwise col_cnt+1.
- Latency: registered outputs appear 1 cycle after the accepting edge, i.e. on the cycle after in_valid.
- out_valid is 1 for exactly one cycle per accepted sample, only in STREAM; otherwise 0.
- Taps hold their value when in_valid=0. Tap registers update in FILL too, but out_valid stays 0.
- State machine:
  - IDLE: in_valid without in_sof is ignored. in_valid & in_sof → sample accepted as row 0, col 0; → FILL, line_cnt=0.
  - FILL: line_cnt (0..2) increments on each column wrap. Wrap with line_cnt==2 → STREAM. Samples of rows 0–2 produce out_valid=0.
  - STREAM: every accepted sample produces out_valid=1. Stays in STREAM until in_sof or reset.
- in_sof in any state with in_valid:
  - Forces col=0, wr_sel=0, line_cnt=0, state FILL, and accepts the sample as row 0 col 0.
  - Any partial line is discarded.
  - out_valid=0 for that sample.
- No bottom-edge flush. Frame end is implicit; the next in_sof restarts the frame.
- Edge rows and columns are not replicated here; the downstream scaler controller handles borders.
- Arithmetic: pure data movement, no width change. col_cnt wraps at LINE_WIDTH-1, not at 2^ADDR_W.
- Reset mid-frame: state returns to IDLE and outputs clear on that edge; stream resumes only on the next in_sof.

Test Plan:
(Bench uses LINE_WIDTH=4, ADDR_W=2; pixel value = row*16+col.)
- Reset: hold rst=0 for 3 clocks with in_valid=1 → out_valid=0, all taps=0, out_col=0 during reset and on the first cycle after release.
- Fill then stream: sof + 16 back-to-back samples (rows 0–3) → out_valid stays 0 for the first 12. At row 3 col 0 (cycle after 13th in_valid), out_valid=1 with taps 0,16,32,48 and out_col=0. Row 3 col 3 gives 3,19,35,51 with out_eol=1.
- Rotation: continue into row 4 → row 4 col 2 gives taps 18,34,50,66. Row 5 col 1 gives 33,49,65,81.
- Gaps: insert in_valid=0 for 2 cycles between row 3 col 1 and col 2 → out_valid low for 2 cycles, taps held at 1,17,33,49. Row 3 col 2 then gives 2,18,34,50.
- sof mid-line: in STREAM, assert in_sof at row 4 col 2 with value 0 → out_valid=0 for that sample and the following 11. Re-stream begins at the new row 3 col 0 with taps 0,16,32,48.
- Reset mid-frame: rst=0 for 1 cycle in STREAM, then in_valid without sof → ignored, out_valid=0. A subsequent sof restarts the fill sequence.

Source files
------------

// File: rtl/y_tap_line_buffer.sv
// y_tap_line_buffer
// Vertical tap window generator for the y-direction weight-table stage.
// Stores the three previous lines of the horizontally interpolated raster
// stream. Each accepted sample produces four vertically aligned taps
// (rows n-3..n, same column), registered one cycle after the accepting edge.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   in_valid  in_data / in_sof valid this cycle
//   in_sof    first sample of a frame (qualified by in_valid)
//   in_data   sample, raster order (8 integer + 7 fraction bits)
//   out_valid taps valid (only once three full lines are stored)
//   tap_0..3  rows n-3 (oldest) .. n (current input)
//   out_col   column index of the taps
//   out_eol   taps belong to the last column
module y_tap_line_buffer #(
    parameter int unsigned LINE_WIDTH = 64,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] tap_0,
    output logic [DATA_W-1:0] tap_1,
    output logic [DATA_W-1:0] tap_2,
    output logic [DATA_W-1:0] tap_3,
    output logic [ADDR_W-1:0] out_col,
    output logic              out_eol
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_WIDTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] col_cnt_q, col_cnt_d;
    logic [1:0]        wr_sel_q, wr_sel_d;
    logic [1:0]        line_cnt_q, line_cnt_d;

    logic              out_valid_d;
    logic [DATA_W-1:0] tap_0_d, tap_1_d, tap_2_d, tap_3_d;
    logic [ADDR_W-1:0] out_col_d;
    logic              out_eol_d;

    logic [DATA_W-1:0] line_mem [3][LINE_WIDTH];

    // Modulo-3 increment for the line rotation pointer.
    function automatic logic [1:0] next3(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // A sof sample restarts the frame in the same cycle, so it is handled
    // as if the counters were already cleared and the FSM already in FILL.
    logic              restart, accept, col_wrap;
    logic [ADDR_W-1:0] cur_col;
    logic [1:0]        cur_sel, cur_line, sel_p1, sel_p2;
    state_e            cur_state;
    logic [DATA_W-1:0] rd_0, rd_1, rd_2;

    assign restart   = in_valid & in_sof;
    assign accept    = in_valid & (in_sof | (state_q != IDLE));
    assign cur_col   = restart ? '0 : col_cnt_q;
    assign cur_sel   = restart ? 2'd0 : wr_sel_q;
    assign cur_line  = restart ? 2'd0 : line_cnt_q;
    assign cur_state = restart ? FILL : state_q;
    assign col_wrap  = (cur_col == LAST_COL);
    assign sel_p1    = next3(cur_sel);
    assign sel_p2    = next3(sel_p1);

    // Line being overwritten holds the oldest row (n-3).
    assign rd_0 = line_mem[cur_sel][cur_col];
    assign rd_1 = line_mem[sel_p1][cur_col];
    assign rd_2 = line_mem[sel_p2][cur_col];

    // State register, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            col_cnt_q  <= '0;
            wr_sel_q   <= 2'd0;
            line_cnt_q <= 2'd0;
            out_valid  <= 1'b0;
            tap_0      <= '0;
            tap_1      <= '0;
            tap_2      <= '0;
            tap_3      <= '0;
            out_col    <= '0;
            out_eol    <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_cnt_q  <= col_cnt_d;
            wr_sel_q   <= wr_sel_d;
            line_cnt_q <= line_cnt_d;
            out_valid  <= out_valid_d;
            tap_0      <= tap_0_d;
            tap_1      <= tap_1_d;
            tap_2      <= tap_2_d;
            tap_3      <= tap_3_d;
            out_col    <= out_col_d;
            out_eol    <= out_eol_d;
        end
    end

    // Line memory write; read of the same location above sees the old row.
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            line_mem[cur_sel][cur_col] <= in_data;
        end
    end

    // Next-state: column / line rotation and fill tracking.
    always_comb begin
        state_d    = state_q;
        col_cnt_d  = col_cnt_q;
        wr_sel_d   = wr_sel_q;
        line_cnt_d = line_cnt_q;
        if (accept) begin
            state_d    = cur_state;
            line_cnt_d = cur_line;
            col_cnt_d  = col_wrap ? '0 : cur_col + ADDR_W'(1);
            wr_sel_d   = col_wrap ? sel_p1 : cur_sel;
            if (col_wrap && (cur_state == FILL)) begin
                if (cur_line == 2'd2) begin
                    state_d    = STREAM;
                    line_cnt_d = 2'd0;
                end else begin
                    line_cnt_d = cur_line + 2'd1;
                end
            end
        end
    end

    // Output next values; taps hold when nothing is accepted.
    always_comb begin
        out_valid_d = 1'b0;
        tap_0_d     = tap_0;
        tap_1_d     = tap_1;
        tap_2_d     = tap_2;
        tap_3_d     = tap_3;
        out_col_d   = out_col;
        out_eol_d   = out_eol;
        if (accept) begin
            out_valid_d = (cur_state == STREAM);
            tap_0_d     = rd_0;
            tap_1_d     = rd_1;
            tap_2_d     = rd_2;
            tap_3_d     = in_data;
            out_col_d   = cur_col;
            out_eol_d   = col_wrap;
        end
    end

endmodule

// File: tb/tb_y_tap_line_buffer.sv
// Directed bench for y_tap_line_buffer with LINE_WIDTH=4; pixel = row*16+col.
module tb_y_tap_line_buffer;

    localparam int unsigned LW = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] tap_0, tap_1, tap_2, tap_3;
    logic [AW-1:0] out_col;
    logic          out_eol;

    int errors = 0;
    int checks = 0;

    y_tap_line_buffer #(
        .LINE_WIDTH(LW),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_data  (in_data),
        .out_valid(out_valid),
        .tap_0    (tap_0),
        .tap_1    (tap_1),
        .tap_2    (tap_2),
        .tap_3    (tap_3),
        .out_col  (out_col),
        .out_eol  (out_eol)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v;
        logic sof;
        int   d;
        logic ev;
        logic ct;
        int   t0, t1, t2, t3;
        int   col;
        logic eol;
    } vec_t;

    vec_t vecs[$];

    function automatic int px(input int r, input int c);
        return r * 16 + c;
    endfunction

    function automatic vec_t mk(input logic v, input logic sof, input int d,
                                input logic ev, input logic ct,
                                input int t0, input int t1, input int t2,
                                input int t3, input int col, input logic eol);
        vec_t x;
        x.v = v; x.sof = sof; x.d = d; x.ev = ev; x.ct = ct;
        x.t0 = t0; x.t1 = t1; x.t2 = t2; x.t3 = t3; x.col = col; x.eol = eol;
        return x;
    endfunction

    // Streaming sample with tap check.
    function automatic vec_t st(input int t0, input int t1, input int t2,
                                input int t3, input int col);
        return mk(1'b1, 1'b0, t3, 1'b1, 1'b1, t0, t1, t2, t3, col, col == 3);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input string tag);
        in_valid = x.v;
        in_sof   = x.sof;
        in_data  = DW'(x.d);
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, int'(out_valid), int'(x.ev));
        if (x.ct) begin
            chk({tag, " tap_0"}, int'(tap_0), x.t0);
            chk({tag, " tap_1"}, int'(tap_1), x.t1);
            chk({tag, " tap_2"}, int'(tap_2), x.t2);
            chk({tag, " tap_3"}, int'(tap_3), x.t3);
            chk({tag, " out_col"}, int'(out_col), x.col);
            chk({tag, " out_eol"}, int'(out_eol), int'(x.eol));
        end
    endtask

    // sof followed by rows 0..2 of a frame; none of these produce out_valid.
    task automatic fill_frame(input string tag);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                apply(mk(1'b1, (r == 0) && (c == 0), px(r, c), 1'b0, 1'b0,
                         0, 0, 0, 0, 0, 1'b0), $sformatf("%s r%0dc%0d", tag, r, c));
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = DW'(5);

        // Main vector table: fill, stream, gap, rotation.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                vecs.push_back(mk(1'b1, (r == 0) && (c == 0), px(r, c), 1'b0, 1'b0,
                                  0, 0, 0, 0, 0, 1'b0));
            end
        end
        vecs.push_back(st(0, 16, 32, 48, 0));
        vecs.push_back(st(1, 17, 33, 49, 1));
        vecs.push_back(mk(1'b0, 1'b0, 0, 1'b0, 1'b1, 1, 17, 33, 49, 1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 0, 1'b0, 1'b1, 1, 17, 33, 49, 1, 1'b0));
        vecs.push_back(st(2, 18, 34, 50, 2));
        vecs.push_back(st(3, 19, 35, 51, 3));
        vecs.push_back(st(16, 32, 48, 64, 0));
        vecs.push_back(st(17, 33, 49, 65, 1));
        vecs.push_back(st(18, 34, 50, 66, 2));
        vecs.push_back(st(19, 35, 51, 67, 3));
        vecs.push_back(st(32, 48, 64, 80, 0));
        vecs.push_back(st(33, 49, 65, 81, 1));

        // Reset held 3 clocks with in_valid high.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst%0d out_valid", i), int'(out_valid), 0);
            chk($sformatf("rst%0d taps", i),
                int'(tap_0) + int'(tap_1) + int'(tap_2) + int'(tap_3), 0);
            chk($sformatf("rst%0d out_col", i), int'(out_col), 0);
        end
        rst = 1'b1;
        apply(mk(1'b1, 1'b0, 7, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b0), "post_rst");

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // sof in the middle of a streaming line.
        fill_frame("f2");
        for (int c = 0; c < 4; c++) begin
            apply(mk(1'b1, 1'b0, px(3, c), 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0),
                  $sformatf("f2 r3c%0d", c));
        end
        apply(mk(1'b1, 1'b0, px(4, 0), 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0), "f2 r4c0");
        apply(mk(1'b1, 1'b0, px(4, 1), 1'b1, 1'b1, 17, 33, 49, 65, 1, 1'b0), "f2 r4c1");
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = DW'(0);
        @(posedge clk);
        #1;
        chk("sof_mid out_valid", int'(out_valid), 0);
        chk("sof_mid out_col", int'(out_col), 0);
        chk("sof_mid tap_3", int'(tap_3), 0);
        for (int i = 1; i < 12; i++) begin
            apply(mk(1'b1, 1'b0, px(i / 4, i % 4), 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0),
                  $sformatf("f3 s%0d", i));
        end
        apply(st(0, 16, 32, 48, 0), "f3 restream");

        // Reset mid-frame, then non-sof sample must be ignored.
        rst      = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = DW'(99);
        @(posedge clk);
        #1;
        chk("mid_rst out_valid", int'(out_valid), 0);
        chk("mid_rst taps", int'(tap_0) + int'(tap_1) + int'(tap_2) + int'(tap_3), 0);
        chk("mid_rst out_col", int'(out_col), 0);
        rst = 1'b1;
        apply(mk(1'b1, 1'b0, 99, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b0), "mid_rst ignored");
        apply(mk(1'b1, 1'b0, 98, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b0), "mid_rst ignored2");
        fill_frame("f4");
        apply(st(0, 16, 32, 48, 0), "f4 r3c0");
        apply(st(1, 17, 33, 49, 1), "f4 r3c1");

        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
